// File: rtl/mips_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_dump_pkg
// Purpose : Shared types and defaults for the MIPS state-dump engine.
//           Build option MIPS_DUMP_CHECKSUM_EN adds the CSUM state.
// Revision: 1.0 - initial release
// ============================================================================
package mips_dump_pkg;

  localparam int DEF_DMEM_DEPTH = 8192;
  localparam int DEF_NREG       = 32;

  // Dump sequencer states; CSUM only exists when the checksum word is built in
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DMEM = 3'd1,
    ST_REGS = 3'd2,
    ST_PCW  = 3'd3,
`ifdef MIPS_DUMP_CHECKSUM_EN
    ST_CSUM = 3'd4,
`endif
    ST_FIN  = 3'd5
  } state_t;

  // Region tag carried alongside every stream word
  typedef enum logic [1:0] {
    RG_DMEM = 2'd0,
    RG_REG  = 2'd1,
    RG_PC   = 2'd2,
    RG_CSUM = 2'd3
  } region_t;

endpackage
`default_nettype wire

// File: rtl/dump_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : dump_skid_buf
// Purpose : 2-entry fall-through output buffer. An incoming word is presented
//           combinationally when the buffer is empty, so the stream adds no
//           latency; otherwise words queue in order. Reports occupancy so the
//           producer can throttle its reads.
// Revision: 1.0 - initial release
// ============================================================================
module dump_skid_buf #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_cnt;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;

  assign w_empty = (r_cnt == 2'd0);
  assign o_valid = !w_empty || i_valid;
  assign o_data  = w_empty ? i_data : r_mem[r_rd_ptr];
  assign o_count = r_cnt;
  // A word only needs storing if it cannot leave straight through this cycle
  assign w_push  = i_valid && !(w_empty && i_ready);
  assign w_pop   = !w_empty && i_ready;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= 2'(r_cnt + {1'b0, w_push} - {1'b0, w_pop});
    end
  end

  // Storage array; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/mips_state_dump.sv
`default_nettype none
// ============================================================================
// Module  : mips_state_dump
// Purpose : Streams data memory, the register file and the PC out on a
//           valid/ready port. Every word passes through a one-cycle pending
//           stage (matching the DMEM read latency) into a 2-entry buffer.
//           Build option MIPS_DUMP_CHECKSUM_EN appends an XOR checksum word.
// Revision: 1.0 - initial release
// ============================================================================
module mips_state_dump
  import mips_dump_pkg::*;
#(
  parameter int DMEM_DEPTH = DEF_DMEM_DEPTH,
  parameter int NREG       = DEF_NREG,
  parameter int WORD_W     = 32
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              dmem_rd_en,
  output logic [12:0]       dmem_addr,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic [4:0]        reg_addr,
  input  logic [WORD_W-1:0] reg_rdata,
  input  logic [WORD_W-1:0] pc_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [1:0]        out_region,
  output logic              out_last
);

  localparam int c_BUF_W = WORD_W + 3;

  state_t              r_state;
  logic [12:0]         r_daddr;
  logic [4:0]          r_raddr;
  logic                r_busy;
  logic                r_done;
  logic                r_pend_v;
  region_t             r_pend_rg;
  logic                r_pend_last;
  logic [WORD_W-1:0]   r_pend_data;
`ifdef MIPS_DUMP_CHECKSUM_EN
  logic [WORD_W-1:0]   r_csum;
`endif

  logic [1:0]          w_buf_cnt;
  logic [2:0]          w_occ;
  logic                w_room;
  logic                w_issue;
  region_t             w_iss_rg;
  logic                w_iss_last;
  logic [WORD_W-1:0]   w_iss_data;
  logic [WORD_W-1:0]   w_pend_data;
  logic [c_BUF_W-1:0]  w_out_bus;
  logic                w_final_hs;

  // Buffered words plus the word in flight must leave room for one more
  assign w_occ      = {1'b0, w_buf_cnt} + {2'b00, r_pend_v};
  assign w_room     = (w_occ < 3'd2);
  assign dmem_rd_en = w_issue && (r_state == ST_DMEM);
  assign dmem_addr  = r_daddr;
  assign reg_addr   = r_raddr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign w_final_hs = out_valid && out_ready && out_last;

  // Decide whether a word issues this cycle and what it carries
  always_comb begin
    w_issue    = 1'b0;
    w_iss_rg   = RG_DMEM;
    w_iss_last = 1'b0;
    w_iss_data = '0;
    case (r_state)
      ST_DMEM: begin
        w_issue = w_room;
      end
      ST_REGS: begin
        w_issue    = w_room;
        w_iss_rg   = RG_REG;
        w_iss_data = reg_rdata;
      end
      ST_PCW: begin
        w_issue    = w_room;
        w_iss_rg   = RG_PC;
        w_iss_data = pc_in;
`ifdef MIPS_DUMP_CHECKSUM_EN
        w_iss_last = 1'b0;
`else
        w_iss_last = 1'b1;
`endif
      end
`ifdef MIPS_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        w_issue    = w_room;
        w_iss_rg   = RG_CSUM;
        w_iss_last = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // DMEM data arrives from memory now; checksum is taken once all prior words are in
  always_comb begin
    w_pend_data = r_pend_data;
    if (r_pend_rg == RG_DMEM) w_pend_data = dmem_rdata;
`ifdef MIPS_DUMP_CHECKSUM_EN
    if (r_pend_rg == RG_CSUM) w_pend_data = r_csum;
`endif
  end

  // Dump sequencer: walks DMEM, registers, PC (and checksum), then waits for drain
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_daddr <= 13'd0;
      r_raddr <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_DMEM;
            r_busy  <= 1'b1;
            r_daddr <= 13'd0;
            r_raddr <= 5'd0;
          end
        end
        ST_DMEM: begin
          if (w_issue) begin
            if (r_daddr == 13'(DMEM_DEPTH - 1)) r_state <= ST_REGS;
            else                                r_daddr <= r_daddr + 13'd1;
          end
        end
        ST_REGS: begin
          if (w_issue) begin
            if (r_raddr == 5'(NREG - 1)) r_state <= ST_PCW;
            else                         r_raddr <= r_raddr + 5'd1;
          end
        end
        ST_PCW: begin
`ifdef MIPS_DUMP_CHECKSUM_EN
          if (w_issue) r_state <= ST_CSUM;
`else
          if (w_issue) r_state <= ST_FIN;
`endif
        end
`ifdef MIPS_DUMP_CHECKSUM_EN
        ST_CSUM: begin
          if (w_issue) r_state <= ST_FIN;
        end
`endif
        ST_FIN: begin
          // The final word leaving the port is the moment the buffer drains
          if (w_final_hs) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pending stage: one word in flight, aligned with the DMEM read latency
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_pend_v    <= 1'b0;
      r_pend_rg   <= RG_DMEM;
      r_pend_last <= 1'b0;
      r_pend_data <= '0;
    end else begin
      r_pend_v    <= w_issue;
      r_pend_rg   <= w_iss_rg;
      r_pend_last <= w_issue && w_iss_last;
      r_pend_data <= w_iss_data;
    end
  end

`ifdef MIPS_DUMP_CHECKSUM_EN
  // Running XOR of every word entering the output buffer
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_csum <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_csum <= '0;
    end else if (r_pend_v) begin
      r_csum <= r_csum ^ w_pend_data;
    end
  end
`endif

  dump_skid_buf #(
    .W (c_BUF_W)
  ) u_skid (
    .clk     (clk1),
    .rst     (rst),
    .i_valid (r_pend_v),
    .i_data  ({w_pend_data, r_pend_rg, r_pend_last}),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (w_out_bus),
    .o_count (w_buf_cnt)
  );

  assign out_data   = w_out_bus[c_BUF_W-1:3];
  assign out_region = w_out_bus[2:1];
  assign out_last   = w_out_bus[0];

endmodule
`default_nettype wire

// File: tb/tb_mips_state_dump.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_state_dump
// Purpose : Directed self-checking bench for mips_state_dump with a DMEM
//           model, a register-file model and an expected-word model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_state_dump;

  localparam int c_DEPTH = 8192;
  localparam int c_NREG  = 32;
`ifdef MIPS_DUMP_CHECKSUM_EN
  localparam int c_TOTAL = c_DEPTH + c_NREG + 2;
  localparam bit c_CSUM  = 1'b1;
`else
  localparam int c_TOTAL = c_DEPTH + c_NREG + 1;
  localparam bit c_CSUM  = 1'b0;
`endif

  logic        clk1 = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        dmem_rd_en;
  logic [12:0] dmem_addr;
  logic [31:0] dmem_rdata;
  logic [4:0]  reg_addr;
  logic [31:0] reg_rdata;
  logic [31:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_region;
  logic        out_last;

  bit          all_ones;
  bit          rnd;
  logic [31:0] exp_csum;
  int          n_checks = 0;
  int          n_errors = 0;
  int          tid = 0;
  int          mon_tid = 0;
  int          idx = 0;
  int          ndone = 0;
  int          last_cyc = -1;
  int          cyc = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] last_data = '0;

  mips_state_dump dut (
    .clk1       (clk1),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .dmem_rd_en (dmem_rd_en),
    .dmem_addr  (dmem_addr),
    .dmem_rdata (dmem_rdata),
    .reg_addr   (reg_addr),
    .reg_rdata  (reg_rdata),
    .pc_in      (pc_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_region (out_region),
    .out_last   (out_last)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  // Memory and register-file models
  always @(posedge clk1) begin
    if (dmem_rd_en) dmem_rdata <= all_ones ? 32'hFFFF_FFFF : 32'(dmem_addr);
  end
  assign reg_rdata = all_ones ? 32'h0 : 32'h100 + 32'(reg_addr);
  assign pc_in     = all_ones ? 32'h1 : 32'h40;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected {data, region, last} of stream word i
  function automatic logic [34:0] exp_word(input int i);
    if (i < c_DEPTH)
      return {(all_ones ? 32'hFFFF_FFFF : 32'(i)), 2'd0, 1'b0};
    else if (i < c_DEPTH + c_NREG)
      return {(all_ones ? 32'h0 : 32'h100 + 32'(i - c_DEPTH)), 2'd1, 1'b0};
    else if (i == c_DEPTH + c_NREG)
      return {(all_ones ? 32'h1 : 32'h40), 2'd2, !c_CSUM};
    else
      return {exp_csum, 2'd3, 1'b1};
  endfunction

  task automatic calc_csum();
    logic [34:0] w;
    exp_csum = '0;
    for (int i = 0; i <= c_DEPTH + c_NREG; i++) begin
      w = exp_word(i);
      exp_csum = exp_csum ^ w[34:3];
    end
  endtask

  // Sink-ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk1);
      #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Stream monitor: every presented word must equal the model's next word
  initial begin
    forever begin
      @(negedge clk1);
      if (tid != mon_tid) begin
        mon_tid    = tid;
        idx        = 0;
        prev_stall = 1'b0;
      end
      if (done) ndone++;
      if (prev_stall) check_val("stall_hold_valid", 64'(out_valid), 64'd1);
      if (out_valid) begin
        if (idx < c_TOTAL) check_val("word", 64'({out_data, out_region, out_last}), 64'(exp_word(idx)));
        else               check_val("word_overrun", 64'(idx), 64'(c_TOTAL - 1));
        if (out_ready) begin
          if (out_last) begin
            last_cyc  = cyc;
            last_data = out_data;
          end
          idx++;
        end
      end
      prev_stall = out_valid && !out_ready;
    end
  end

  task automatic start_dump(input string tag);
    @(posedge clk1); #1 start = 1'b1;
    @(posedge clk1); #1 start = 1'b0;
    @(negedge clk1);
    check_val({tag, "_busy"},     64'(busy), 64'd1);
    check_val({tag, "_early_vld"}, 64'(out_valid), 64'd0);
    check_val({tag, "_rd_en"},    64'(dmem_rd_en), 64'd1);
    check_val({tag, "_addr0"},    64'(dmem_addr), 64'd0);
    @(negedge clk1);
    check_val({tag, "_first_vld"}, 64'(out_valid), 64'd1);
  endtask

  task automatic finish_dump(input string tag);
    int  n0;
    bit  seen;
    n0   = ndone;
    seen = 1'b0;
    for (int k = 0; k < 40000; k++) begin
      @(negedge clk1);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check_val({tag, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      check_val({tag, "_done_lat"}, 64'(cyc - last_cyc), 64'd1);
      @(negedge clk1);
      check_val({tag, "_done_pulse"}, 64'(done), 64'd0);
      check_val({tag, "_busy_end"},   64'(busy), 64'd0);
    end
    repeat (5) @(negedge clk1);
    check_val({tag, "_nwords"}, 64'(idx), 64'(c_TOTAL));
    check_val({tag, "_ndone"},  64'(ndone - n0), 64'd1);
  endtask

  initial begin
    int n0;
    rst      = 1'b1;
    start    = 1'b0;
    all_ones = 1'b0;
    rnd      = 1'b0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check_val("rst_busy",  64'(busy), 64'd0);
    check_val("rst_done",  64'(done), 64'd0);
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_rd_en", 64'(dmem_rd_en), 64'd0);
    check_val("rst_last",  64'(out_last), 64'd0);
    rst = 1'b0;
    calc_csum();

    // Full dump with an always-ready sink
    tid = 1;
    start_dump("A");
    finish_dump("A");

    // Same dump with a stalling sink
    rnd = 1'b1;
    tid = 2;
    start_dump("B");
    finish_dump("B");
    rnd = 1'b0;
    repeat (3) @(negedge clk1);

    // Reset in the middle of the DMEM sweep
    tid = 3;
    start_dump("C");
    for (int k = 0; k < 2000; k++) begin
      if (dmem_rd_en && dmem_addr == 13'd500) break;
      @(negedge clk1);
    end
    check_val("C_reach500", 64'(dmem_addr), 64'd500);
    rst = 1'b1;
    @(posedge clk1); #1 rst = 1'b0;
    @(negedge clk1);
    check_val("C_rst_valid", 64'(out_valid), 64'd0);
    check_val("C_rst_busy",  64'(busy), 64'd0);
    check_val("C_rst_rd_en", 64'(dmem_rd_en), 64'd0);
    check_val("C_rst_last",  64'(out_last), 64'd0);
    n0 = ndone;
    repeat (5) @(negedge clk1);
    check_val("C_no_done", 64'(ndone - n0), 64'd0);

    // Restart from address 0, with a second start while busy
    tid = 4;
    start_dump("D");
    @(posedge clk1); #1 start = 1'b1;
    @(posedge clk1); #1 start = 1'b0;
    finish_dump("D");

`ifdef MIPS_DUMP_CHECKSUM_EN
    // Checksum word over all-ones memory, zero registers and pc=1
    all_ones = 1'b1;
    calc_csum();
    tid = 5;
    start_dump("E");
    finish_dump("E");
    check_val("E_csum", 64'(last_data), 64'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_state_dump.md
MIPS_STATE_DUMP -- requirements
Module: mips_state_dump

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- DMEM_DEPTH, 8192, data-memory words scanned.
- NREG, 32, register-file entries scanned.
- WORD_W, 32, datapath width.
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk1, in, 1, single clock, rising-edge.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle request to begin a dump.
- busy, out, 1, dump in progress.
- done, out, 1, one-cycle completion pulse.
- dmem_rd_en, out, 1, data-memory read strobe.
- dmem_addr, out, 13, word address.
- dmem_rdata, in, WORD_W, read data, valid the cycle after dmem_rd_en.
- reg_addr, out, 5, register index.
- reg_rdata, in, WORD_W, combinational read of reg_addr.
- pc_in, in, WORD_W, current program counter.
- out_valid, out, 1, stream word valid.
- out_ready, in, 1, sink accepts word.
- out_data, out, WORD_W, stream word.
- out_region, out, 2, 0=DMEM, 1=REG, 2=PC, 3=CSUM.
- out_last, out, 1, final word of dump.

Function
REQ-003 The FSM SHALL have states IDLE, DMEM, REGS, PCW, CSUM (present only with the macro) and FIN.
REQ-004 IDLE->DMEM SHALL occur on start; start while busy=1 SHALL be ignored.
REQ-005 DMEM SHALL read addresses 0..DMEM_DEPTH-1 in ascending order and then enter REGS.
REQ-006 REGS SHALL read indices 0..NREG-1 in ascending order and then enter PCW.
REQ-007 PCW SHALL emit one pc_in word sampled at issue, then enter CSUM or FIN.
REQ-008 FIN SHALL wait for the output buffer to drain, assert done for one cycle, and return to IDLE.
REQ-009 A 2-entry output buffer SHALL hold words; a read SHALL issue only if occupancy plus in-flight reads is below 2.
REQ-010 The stream SHALL be ordered, lossless and gap-free, sustaining 1 word/cycle while out_ready=1 after the first word.
REQ-011 The first word SHALL appear with out_valid=1 exactly 2 cycles after start (DMEM read latency 1).
REQ-012 While out_valid=1 and out_ready=0, out_data, out_region and out_last SHALL remain stable.
REQ-013 Total words SHALL be DMEM_DEPTH+NREG+1 (+1 with the macro); out_last SHALL mark only the final word.
REQ-014 busy SHALL be 1 from the cycle after start until the cycle done pulses.
REQ-015 Address counters SHALL not wrap; the terminal index SHALL trigger the state change.

Reset
REQ-016 rst SHALL force state IDLE, counters 0, buffer empty, in-flight flag clear, and busy, done, out_valid, dmem_rd_en, out_last all 0.
REQ-017 rst mid-dump SHALL abort it with no done pulse; the next start SHALL restart from DMEM address 0.

Configuration
REQ-018 With MIPS_DUMP_CHECKSUM_EN defined, a CSUM word (XOR of all prior words) SHALL follow the PC word with out_region=3 and out_last=1.
REQ-019 Without MIPS_DUMP_CHECKSUM_EN, the CSUM state and logic SHALL be absent and the PC word SHALL carry out_last=1.

Structure
REQ-020 Package mips_dump_pkg SHALL hold the state enum, the region codes, and the DMEM_DEPTH/NREG defaults.
REQ-021 The output buffer SHALL be sub-module dump_skid_buf (2-entry, valid/ready, carries data+region+last).

Verification
REQ-022 DMEM[k]=k, reg[k]=0x100+k, pc=0x40, out_ready=1, start -> 8225 words: 0..8191, 0x100..0x11F, 0x40; last on 0x40; done 1 cycle later.
REQ-023 out_ready toggled pseudo-randomly at 50% -> identical sequence to REQ-022, no drop or duplicate, stable data while stalled.
REQ-024 rst asserted at DMEM address 500, then start -> outputs clear the next cycle, no done, new dump begins at address 0.
REQ-025 start pulsed again while busy -> ignored; exactly one done and 8225 words.
REQ-026 Macro defined, all DMEM=0xFFFFFFFF, regs=0, pc=0x1 -> final CSUM word 0x00000001 with region 3 and last=1; total 8226 words.
